// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: width helpers and the bit-to-phase mapping
// used by both the modulator and this demodulator.
package bpsk_pkg;

    // A data bit of 1 is carried as +sin, a 0 as -sin.
    localparam logic BIT_ONE_PHASE = 1'b1;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            result = ((32'sd1 <<< i) < value) ? (i + 32'sd1) : result;
        end
        return result;
    endfunction

    // Accumulator width that holds SPS full-scale products without wrap.
    function automatic int acc_width(input int in_w, input int sps);
        return (32'sd2 * in_w) + clog2(sps);
    endfunction

endpackage

// File: rtl/bpsk_mac.sv
// Two-stage multiply / integrate-and-dump correlator. Stage 1 forms the
// full-precision product; stage 2 adds it to the running symbol sum and
// dumps the total when the last sample of a symbol arrives.
module bpsk_mac
    import bpsk_pkg::*;
#(
    parameter int INPUT_WIDTH = 12,
    parameter int ACC_WIDTH   = 29
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [INPUT_WIDTH-1:0] adc,
    input  logic [INPUT_WIDTH-1:0] carrier,
    output logic                   dump_valid,
    output logic [ACC_WIDTH-1:0]   dump_sum
);

    localparam int PW = 2 * INPUT_WIDTH;

    logic signed [PW-1:0]        prod_r;
    logic                        s1_valid_r;
    logic                        s1_first_r;
    logic                        s1_last_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] base_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] sum_s;

    // Stage 1: register the signed product with its symbol-position tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r     <= {PW{1'b0}};
            s1_valid_r <= 1'b0;
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
        end else begin
            s1_valid_r <= in_valid;
            s1_first_r <= in_first;
            s1_last_r  <= in_last;
            if (in_valid) begin
                prod_r <= $signed(adc) * $signed(carrier);
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    // A first sample starts from zero, discarding any truncated partial sum.
    always_comb begin
        base_s     = s1_first_r ? {ACC_WIDTH{1'b0}} : acc_r;
        prod_ext_s = {{(ACC_WIDTH - PW){prod_r[PW-1]}}, prod_r};
        sum_s      = base_s + prod_ext_s;
    end

    // Stage 2: integrate, or dump the completed symbol sum and restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            dump_valid <= 1'b0;
            dump_sum   <= {ACC_WIDTH{1'b0}};
        end else if (s1_valid_r) begin
            if (s1_last_r) begin
                dump_sum   <= sum_s;
                dump_valid <= 1'b1;
                acc_r      <= {ACC_WIDTH{1'b0}};
            end else begin
                acc_r      <= sum_s;
                dump_valid <= 1'b0;
            end
        end else begin
            dump_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: tracks the sample position within a symbol,
// feeds the correlator, and slices each symbol's correlation into a bit.
module bpsk_demod
    import bpsk_pkg::*;
#(
    parameter int INPUT_WIDTH        = 12,
    parameter int SAMPLES_PER_SYMBOL = 32,
    parameter int ACC_WIDTH          = acc_width(INPUT_WIDTH, SAMPLES_PER_SYMBOL)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [INPUT_WIDTH-1:0] adc_in,
    input  logic [INPUT_WIDTH-1:0] sine_c,
    input  logic                   symbol_start,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic [ACC_WIDTH-1:0]   corr_out
);

    localparam int               IDX_W    = clog2(SAMPLES_PER_SYMBOL);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

    logic [IDX_W-1:0]     idx_r;
    logic                 first_s;
    logic                 last_s;
    logic                 dump_valid_s;
    logic [ACC_WIDTH-1:0] dump_sum_s;

    // Tag each accepted sample; a resync forces it to be the symbol's first.
    always_comb begin
        first_s = (idx_r == IDX_ZERO) || symbol_start;
        last_s  = (idx_r == IDX_LAST) && !symbol_start;
    end

    // Sample index within the symbol, restarted by resync.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= IDX_ZERO;
        end else if (symbol_start) begin
            idx_r <= sample_valid ? IDX_ONE : IDX_ZERO;
        end else if (sample_valid) begin
            idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
        end else begin
            idx_r <= idx_r;
        end
    end

    bpsk_mac #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (sample_valid),
        .in_first   (first_s),
        .in_last    (last_s),
        .adc        (adc_in),
        .carrier    (sine_c),
        .dump_valid (dump_valid_s),
        .dump_sum   (dump_sum_s)
    );

    // Slicer: non-negative correlation (including zero) decides the +sin bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            corr_out  <= {ACC_WIDTH{1'b0}};
        end else if (dump_valid_s) begin
            bit_out   <= dump_sum_s[ACC_WIDTH-1] ? ~BIT_ONE_PHASE : BIT_ONE_PHASE;
            bit_valid <= 1'b1;
            corr_out  <= dump_sum_s;
        end else begin
            bit_out   <= bit_out;
            bit_valid <= 1'b0;
            corr_out  <= corr_out;
        end
    end

endmodule

// File: tb/tb_bpsk_demod.sv
// Self-checking bench for bpsk_demod: a symbol-level reference model
// (products collected per symbol, summed when complete, delivered two
// edges later) checked every cycle, plus directed literal checks.
module tb_bpsk_demod;
    import bpsk_pkg::*;

    localparam int W   = 12;
    localparam int SPS = 4;
    localparam int AW  = acc_width(W, SPS);

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [W-1:0]  adc_in;
    logic [W-1:0]  sine_c;
    logic          symbol_start;
    logic          bit_out;
    logic          bit_valid;
    logic [AW-1:0] corr_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint sym_q[$];
    int     due_q[$];
    longint sum_q[$];
    int     cyc = 0;
    logic   exp_bv = 1'b0;
    logic   exp_bit = 1'b0;
    longint exp_corr = 0;
    bit     armed = 1'b0;
    int     strobe_cnt = 0;
    int     strobe_cyc = -1;
    int     last_acc_cyc = 0;

    always #5 clk = ~clk;

    bpsk_demod #(
        .INPUT_WIDTH        (W),
        .SAMPLES_PER_SYMBOL (SPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .adc_in       (adc_in),
        .sine_c       (sine_c),
        .symbol_start (symbol_start),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .corr_out     (corr_out)
    );

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, update the model at the edge, compare at negedge.
    task automatic step(input logic v, input int a, input int s,
                        input logic ss, input logic r);
        longint tot;
        rst          = r;
        sample_valid = v;
        adc_in       = a[W-1:0];
        sine_c       = s[W-1:0];
        symbol_start = ss;
        @(posedge clk);
        cyc++;
        if (r) begin
            sym_q.delete();
            due_q.delete();
            sum_q.delete();
            exp_bv   = 1'b0;
            exp_bit  = 1'b0;
            exp_corr = 0;
            armed    = 1'b1;
        end else begin
            exp_bv = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                exp_bv   = 1'b1;
                exp_corr = sum_q[0];
                exp_bit  = (sum_q[0] >= 0);
                void'(due_q.pop_front());
                void'(sum_q.pop_front());
            end
            if (ss) sym_q.delete();
            if (v) begin
                sym_q.push_back(longint'(a) * longint'(s));
                if (sym_q.size() == SPS) begin
                    tot = 0;
                    foreach (sym_q[i]) tot += sym_q[i];
                    due_q.push_back(cyc + 2);
                    sum_q.push_back(tot);
                    sym_q.delete();
                    last_acc_cyc = cyc;
                end
            end
        end
        @(negedge clk);
        if (armed) begin
            chk("bit_valid", bit_valid, exp_bv);
            chk("bit_out", bit_out, exp_bit);
            chk("corr_out", $signed(corr_out), exp_corr);
        end
        if (bit_valid === 1'b1) begin
            strobe_cnt++;
            strobe_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic symbol(input int a, input int s, input bit gaps);
        for (int i = 0; i < SPS; i++) begin
            if (gaps) step(1'b0, 0, 0, 1'b0, 1'b0);
            step(1'b1, a, s, 1'b0, 1'b0);
        end
    endtask

    // Literal expectations after a directed symbol has drained.
    task automatic dir_check(input string name, input int cnt0,
                             input longint corr, input logic b);
        chk({name, "_strobes"}, strobe_cnt - cnt0, 1);
        chk({name, "_corr"}, $signed(corr_out), corr);
        chk({name, "_bit"}, bit_out, b);
        chk({name, "_model_corr"}, exp_corr, corr);
        chk({name, "_latency"}, strobe_cyc - last_acc_cyc, 2);
    endtask

    initial begin
        int c0;
        int a;
        int s;
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        chk("reset_bit_valid", bit_valid, 0);
        chk("reset_bit_out", bit_out, 0);
        chk("reset_corr", $signed(corr_out), 0);
        idle(2);

        c0 = strobe_cnt; symbol(1000, 1000, 1'b0); idle(3);
        dir_check("pos", c0, 4000000, 1'b1);

        c0 = strobe_cnt; symbol(-1000, 1000, 1'b0); idle(3);
        dir_check("neg", c0, -4000000, 1'b0);

        c0 = strobe_cnt; symbol(0, 1000, 1'b0); idle(3);
        dir_check("tie", c0, 0, 1'b1);

        c0 = strobe_cnt; symbol(-2048, -2048, 1'b0); idle(3);
        dir_check("maxneg", c0, 16777216, 1'b1);

        c0 = strobe_cnt; symbol(1000, 1000, 1'b1); idle(3);
        dir_check("gaps", c0, 4000000, 1'b1);

        c0 = strobe_cnt;
        step(1'b1, 1000, 1000, 1'b0, 1'b0);
        step(1'b1, 1000, 1000, 1'b0, 1'b0);
        step(1'b1, -500, 1000, 1'b1, 1'b0);
        for (int i = 0; i < SPS - 1; i++) step(1'b1, -500, 1000, 1'b0, 1'b0);
        idle(3);
        dir_check("resync", c0, -2000000, 1'b0);

        for (int i = 0; i < 3; i++) step(1'b1, 1000, 1000, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        chk("midrst_bit_valid", bit_valid, 0);
        chk("midrst_corr", $signed(corr_out), 0);
        chk("midrst_bit", bit_out, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        c0 = strobe_cnt; symbol(1000, 1000, 1'b0); idle(3);
        dir_check("postrst", c0, 4000000, 1'b1);

        // Randomized traffic with gaps, resyncs, occasional resets and extremes.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       a = -2048;
                1:       a = 2047;
                default: a = int'($urandom_range(0, 4095)) - 2048;
            endcase
            s = ($urandom_range(0, 3) == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
            step($urandom_range(0, 99) < 75, a, s,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 199) < 2);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpsk_demod.md
Name: bpsk_demod

Overview:
Coherent BPSK demodulator and the receive-side counterpart of the BPSK modulator. It multiplies each signed ADC sample by the local, phase-aligned sine carrier and integrates the products over one symbol period. At the symbol boundary it slices the sign of the sum into a data bit. It sits between the ADC capture logic and the bit-level deframer.

Parameters:
INPUT_WIDTH, 12, width of adc_in and sine_c (two's complement, same format as the modulator's dac_out/sine_c)
SAMPLES_PER_SYMBOL, 32, carrier samples integrated per bit; must be >= 2
ACC_WIDTH, 2*INPUT_WIDTH+clog2(SAMPLES_PER_SYMBOL), correlator accumulator width; must not be overridden smaller

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
sample_valid  input  1  adc_in/sine_c valid this cycle
adc_in  input  INPUT_WIDTH  received sample, signed two's complement
sine_c  input  INPUT_WIDTH  local carrier sample, signed, phase-aligned to adc_in
symbol_start  input  1  resync: next accepted sample is index 0 of a new symbol
bit_out  output  1  decided bit; 1 = in-phase (+sin), 0 = inverted (-sin)
bit_valid  output  1  one-cycle strobe, bit_out/corr_out valid
corr_out  output  ACC_WIDTH  signed integrated correlation of the decided symbol

Behaviour:
- Reset (rst high at a clk edge): bit_out=0, bit_valid=0, corr_out=0. Sample counter=0, accumulator=0, all pipeline valid flags=0. Takes priority over every other input.
- Sample counter idx, 0..SAMPLES_PER_SYMBOL-1:
  - Advances only on sample_valid.
  - Wraps to 0 after SAMPLES_PER_SYMBOL-1.
  - Tags each accepted sample: first = (idx==0 or symbol_start), last = (idx==SAMPLES_PER_SYMBOL-1 and not symbol_start).
- symbol_start:
  - With sample_valid high: that sample is index 0 and idx becomes 1.
  - Without sample_valid: idx is forced to 0.
  - In both cases any partial sum is discarded; no bit is emitted for the truncated symbol.
- Stage 1 (edge after acceptance): prod = signed(adc_in)*signed(sine_c), full 2*INPUT_WIDTH bits. first/last/valid flags are registered alongside.
- Stage 2 (next edge, if stage-1 valid):
  - base = first ? 0 : acc; sum = base + sign-extended prod.
  - If last: corr_out<=sum, bit_out<=(sum>=0), bit_valid<=1, acc<=0.
  - Else: acc<=sum, bit_valid<=0.
- Latency: last sample accepted at edge k gives bit_valid high for exactly the cycle following edge k+2.
- Tie rule: sum==0 decides bit_out=1.
- bit_valid is high for one cycle per symbol. bit_out and corr_out hold their values until the next decision.
- Gaps (sample_valid low) insert bubbles. The accumulator holds, and no timing constraint applies between samples.
- No overflow is possible with the default ACC_WIDTH: the worst case is (-2^(W-1))^2 * SPS.
- No output handshake. The consumer must accept every bit_valid strobe.

Decomposition:
- Package bpsk_pkg: clog2 function, ACC_WIDTH derivation, and the BIT_ONE_PHASE constant (1 = +sin), shared with the modulator.
- One natural sub-module, bpsk_mac: the stage-1 multiplier plus stage-2 accumulate/dump with first/last flags.
- The top level holds the sample counter, resync logic and the slicer.

Test Plan (bench overrides SAMPLES_PER_SYMBOL=4, INPUT_WIDTH=12):
- adc_in=1000, sine_c=1000 for 4 consecutive valid cycles -> one bit_valid strobe 2 cycles after the 4th sample; corr_out=4,000,000; bit_out=1.
- adc_in=-1000, sine_c=1000 for 4 samples -> corr_out=-4,000,000, bit_out=0. Then adc_in=0 for 4 samples -> corr_out=0, bit_out=1 (tie rule).
- adc_in=-2048, sine_c=-2048 for 4 samples -> corr_out=16,777,216, no wrap, bit_out=1.
- Same positive symbol with sample_valid low on alternate cycles -> identical corr_out=4,000,000, strobe 2 cycles after the 4th valid sample, exactly one strobe.
- 2 samples of +1000*1000, then symbol_start with 4 samples of -500*1000 -> one strobe only, corr_out=-2,000,000, bit_out=0.
- rst pulsed after 3 samples, then 4 samples of +1000*1000 -> outputs 0 during reset; single strobe with corr_out=4,000,000 and no residue from pre-reset samples.
